// File: rtl/router_inject_port.sv
// Transmit side of a credit-based router channel: accepts client flits, enforces
// packet framing per VC, tracks per-VC credits and registers the outgoing flit.
module router_inject_port #(
    parameter int FLIT_DATA_WIDTH    = 64,
    parameter int NUM_VCS            = 2,
    parameter int VC_BUFFER_DEPTH    = 32,
    parameter int MAX_PAYLOAD_LENGTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         src_valid,
    output logic                         src_ready,
    input  logic                         src_vc,
    input  logic                         src_head,
    input  logic                         src_tail,
    input  logic [0:FLIT_DATA_WIDTH-1]   src_data,
    output logic [0:FLIT_DATA_WIDTH+3]   channel_out,
    input  logic [0:1]                   flow_ctrl_in,
    output logic [0:5]                   credit_count_vc0,
    output logic [0:5]                   credit_count_vc1,
    output logic                         error
);

    localparam int CW = 6;
    localparam int FW = $clog2(MAX_PAYLOAD_LENGTH + 2);
    localparam logic [CW-1:0] DEPTH_C   = CW'(VC_BUFFER_DEPTH);
    localparam logic [FW-1:0] MAX_PAY_C = FW'(MAX_PAYLOAD_LENGTH);

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    state_t              state_q, state_d;
    logic                lock_vc_q, lock_vc_d;
    logic [FW-1:0]       flit_cnt_q, flit_cnt_d;
    logic [CW-1:0]       credit_q [NUM_VCS];
    logic [CW-1:0]       credit_d [NUM_VCS];
    logic [NUM_VCS-1:0]  dec_vc, inc_vc;
    logic                accept, send, force_tail, proto_err, credit_err;
    logic [0:FLIT_DATA_WIDTH+3] channel_d;

    // Ready looks only at the registered count, so a same-cycle credit return never bypasses.
    assign src_ready = (credit_q[src_vc] != '0);
    assign accept    = src_valid && src_ready;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        lock_vc_d  = lock_vc_q;
        flit_cnt_d = flit_cnt_q;
        send       = 1'b0;
        force_tail = 1'b0;
        proto_err  = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (src_head) begin
                        send = 1'b1;
                        if (!src_tail) begin
                            state_d    = BODY;
                            lock_vc_d  = src_vc;
                            flit_cnt_d = FW'(1);
                        end
                    end else begin
                        proto_err = 1'b1;
                    end
                end
                BODY: begin
                    if (src_head || (src_vc != lock_vc_q)) begin
                        proto_err = 1'b1;
                    end else begin
                        send       = 1'b1;
                        flit_cnt_d = flit_cnt_q + FW'(1);
                        if (src_tail) begin
                            state_d    = IDLE;
                            flit_cnt_d = '0;
                        end else if (flit_cnt_q == MAX_PAY_C) begin
                            // Longest legal packet reached without a tail: close it ourselves.
                            force_tail = 1'b1;
                            proto_err  = 1'b1;
                            state_d    = IDLE;
                            flit_cnt_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dec_vc     = '0;
        inc_vc     = '0;
        credit_err = 1'b0;
        if (send)            dec_vc[src_vc]          = 1'b1;
        if (flow_ctrl_in[0]) inc_vc[flow_ctrl_in[1]] = 1'b1;
        for (int v = 0; v < NUM_VCS; v++) begin
            credit_d[v] = credit_q[v];
            if (inc_vc[v] && !dec_vc[v]) begin
                if (credit_q[v] == DEPTH_C) credit_err  = 1'b1;
                else                        credit_d[v] = credit_q[v] + CW'(1);
            end else if (dec_vc[v] && !inc_vc[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end
        end
    end

    always_comb begin
        channel_d = '0;
        if (send) channel_d = {1'b1, src_vc, src_head, src_tail | force_tail, src_data};
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_vc_q   <= 1'b0;
            flit_cnt_q  <= '0;
            channel_out <= '0;
            error       <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= DEPTH_C;
        end else begin
            state_q     <= state_d;
            lock_vc_q   <= lock_vc_d;
            flit_cnt_q  <= flit_cnt_d;
            channel_out <= channel_d;
            error       <= error | proto_err | credit_err;
            for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= credit_d[v];
        end
    end

    assign credit_count_vc0 = credit_q[0];
    assign credit_count_vc1 = credit_q[1];

endmodule
